// File: rtl/ddr_axi_wr_master.sv
// Burst-request to AXI4 write master with a 4-entry prefetch buffer (ddr_clk domain).
// Define DDR_AXI_WR_BRESP_CNT_EN to build the saturating non-OKAY response counter.
module ddr_axi_wr_master #(
    parameter int unsigned DDR_ADDR_WD = 32,
    parameter int unsigned DDR_DATA_WD = 512,
    parameter int unsigned ADDR_SHIFT  = 3,
    parameter logic [3:0]  AXI_ID      = 4'd0
) (
    input  logic                       ddr_clk,
    input  logic                       ddr_rst_n,
    input  logic                       wr_burst_req,
    input  logic [9:0]                 wr_burst_len,
    input  logic [DDR_ADDR_WD-1:0]     wr_burst_addr,
    output logic                       wr_burst_data_req,
    input  logic [DDR_DATA_WD-1:0]     wr_burst_data,
    output logic                       wr_burst_finish,
    output logic [3:0]                 m_axi_awid,
    output logic [DDR_ADDR_WD-1:0]     m_axi_awaddr,
    output logic [7:0]                 m_axi_awlen,
    output logic [2:0]                 m_axi_awsize,
    output logic [1:0]                 m_axi_awburst,
    output logic                       m_axi_awvalid,
    input  logic                       m_axi_awready,
    output logic [DDR_DATA_WD-1:0]     m_axi_wdata,
    output logic [DDR_DATA_WD/8-1:0]   m_axi_wstrb,
    output logic                       m_axi_wlast,
    output logic                       m_axi_wvalid,
    input  logic                       m_axi_wready,
    input  logic [1:0]                 m_axi_bresp,
    input  logic                       m_axi_bvalid,
    output logic                       m_axi_bready,
    output logic                       len_err,
    output logic [31:0]                bresp_err_cnt
);

    localparam int unsigned StrbWd = DDR_DATA_WD / 8;
    localparam logic [2:0]  AwSize = 3'($clog2(StrbWd));

    typedef enum logic [2:0] {StIdle, StAddr, StData, StResp, StFin} state_e;

    state_e                 state_q, state_d;
    logic [8:0]             len_q, len_d;
    logic [7:0]             awlen_q, awlen_d;
    logic [DDR_ADDR_WD-1:0] awaddr_q, awaddr_d;
    logic [8:0]             req_cnt_q, req_cnt_d;
    logic [8:0]             beat_cnt_q, beat_cnt_d;
    logic                   pend_q;
    logic [2:0]             occ_q, occ_d;
    logic [1:0]             wr_ptr_q, wr_ptr_d;
    logic [1:0]             rd_ptr_q, rd_ptr_d;
    logic                   holdoff_q, holdoff_d;
    logic                   len_err_q, len_err_d;
    logic [DDR_DATA_WD-1:0] buf_q [4];

    logic       prefetch, data_req, push, pop, wvalid, wlast;
    logic [8:0] len_clamp;
    logic       len_bad;

    assign len_bad   = (wr_burst_len == 10'd0) || (wr_burst_len > 10'd256);
    assign len_clamp = (wr_burst_len == 10'd0)  ? 9'd1   :
                       (wr_burst_len > 10'd256) ? 9'd256 : wr_burst_len[8:0];

    // Strobe issue depends only on registered state so it never waits on wready.
    assign prefetch = (state_q == StAddr) || (state_q == StData);
    assign data_req = prefetch && (req_cnt_q < len_q) && ((occ_q + 3'(pend_q)) <= 3'd2);
    assign push     = pend_q;
    assign wvalid   = (state_q == StData) && (occ_q != 3'd0);
    assign pop      = wvalid && m_axi_wready;
    assign wlast    = (state_q == StData) && (beat_cnt_q == (len_q - 9'd1));

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        awlen_d    = awlen_q;
        awaddr_d   = awaddr_q;
        req_cnt_d  = req_cnt_q + 9'(data_req);
        beat_cnt_d = beat_cnt_q + 9'(pop);
        holdoff_d  = 1'b0;
        len_err_d  = len_err_q;
        case (state_q)
            StIdle: begin
                if (wr_burst_req && !holdoff_q) begin
                    len_d      = len_clamp;
                    awlen_d    = 8'(len_clamp - 9'd1);
                    awaddr_d   = wr_burst_addr << ADDR_SHIFT;
                    req_cnt_d  = 9'd0;
                    beat_cnt_d = 9'd0;
                    len_err_d  = len_err_q | len_bad;
                    state_d    = StAddr;
                end
            end
            StAddr: if (m_axi_awready) state_d = StData;
            StData: if (pop && wlast) state_d = StResp;
            StResp: if (m_axi_bvalid) state_d = StFin;
            StFin: begin
                // Upstream FIFO count needs one more cycle to settle before a new request.
                holdoff_d = 1'b1;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        occ_d    = occ_q + 3'(push) - 3'(pop);
        wr_ptr_d = wr_ptr_q + 2'(push);
        rd_ptr_d = rd_ptr_q + 2'(pop);
    end

    always_ff @(posedge ddr_clk or negedge ddr_rst_n) begin
        if (!ddr_rst_n) begin
            state_q    <= StIdle;
            len_q      <= 9'd0;
            awlen_q    <= 8'd0;
            awaddr_q   <= '0;
            req_cnt_q  <= 9'd0;
            beat_cnt_q <= 9'd0;
            pend_q     <= 1'b0;
            occ_q      <= 3'd0;
            wr_ptr_q   <= 2'd0;
            rd_ptr_q   <= 2'd0;
            holdoff_q  <= 1'b0;
            len_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            awlen_q    <= awlen_d;
            awaddr_q   <= awaddr_d;
            req_cnt_q  <= req_cnt_d;
            beat_cnt_q <= beat_cnt_d;
            pend_q     <= data_req;
            occ_q      <= occ_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            holdoff_q  <= holdoff_d;
            len_err_q  <= len_err_d;
        end
    end

    always_ff @(posedge ddr_clk or negedge ddr_rst_n) begin
        if (!ddr_rst_n) begin
            for (int i = 0; i < 4; i++) buf_q[i] <= '0;
        end else if (push) begin
            buf_q[wr_ptr_q] <= wr_burst_data;
        end
    end

`ifdef DDR_AXI_WR_BRESP_CNT_EN
    logic [31:0] bresp_err_cnt_q, bresp_err_cnt_d;

    always_comb begin
        bresp_err_cnt_d = bresp_err_cnt_q;
        if ((state_q == StResp) && m_axi_bvalid && (m_axi_bresp != 2'b00) &&
            (bresp_err_cnt_q != 32'hFFFF_FFFF)) begin
            bresp_err_cnt_d = bresp_err_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge ddr_clk or negedge ddr_rst_n) begin
        if (!ddr_rst_n) bresp_err_cnt_q <= 32'd0;
        else            bresp_err_cnt_q <= bresp_err_cnt_d;
    end

    assign bresp_err_cnt = bresp_err_cnt_q;
`else
    logic unused_bresp;
    assign unused_bresp  = ^m_axi_bresp;
    assign bresp_err_cnt = 32'd0;
`endif

    assign wr_burst_data_req = data_req;
    assign wr_burst_finish   = (state_q == StFin);
    assign m_axi_awid        = AXI_ID;
    assign m_axi_awaddr      = awaddr_q;
    assign m_axi_awlen       = awlen_q;
    assign m_axi_awsize      = AwSize;
    assign m_axi_awburst     = 2'b01;
    assign m_axi_awvalid     = (state_q == StAddr);
    assign m_axi_wdata       = buf_q[rd_ptr_q];
    assign m_axi_wstrb       = '1;
    assign m_axi_wlast       = wlast;
    assign m_axi_wvalid      = wvalid;
    assign m_axi_bready      = (state_q == StResp);
    assign len_err           = len_err_q;

endmodule

// File: tb/tb_ddr_axi_wr_master.sv
// Directed bench for ddr_axi_wr_master: upstream FIFO model, AXI slave stubs and a beat monitor.
module tb_ddr_axi_wr_master;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         wr_burst_req = 1'b0;
    logic [9:0]   wr_burst_len = 10'd0;
    logic [31:0]  wr_burst_addr = 32'd0;
    logic         wr_burst_data_req;
    logic [511:0] wr_burst_data;
    logic         wr_burst_finish;
    logic [3:0]   awid;
    logic [31:0]  awaddr;
    logic [7:0]   awlen;
    logic [2:0]   awsize;
    logic [1:0]   awburst;
    logic         awvalid;
    logic         awready = 1'b1;
    logic [511:0] wdata;
    logic [63:0]  wstrb;
    logic         wlast;
    logic         wvalid;
    logic         wready;
    logic [1:0]   bresp = 2'b00;
    logic         bvalid = 1'b1;
    logic         bready;
    logic         len_err;
    logic [31:0]  bresp_err_cnt;

`ifdef DDR_AXI_WR_BRESP_CNT_EN
    localparam int unsigned ExpBrespErr = 2;
`else
    localparam int unsigned ExpBrespErr = 0;
`endif

    ddr_axi_wr_master dut (
        .ddr_clk           (clk),
        .ddr_rst_n         (rst_n),
        .wr_burst_req      (wr_burst_req),
        .wr_burst_len      (wr_burst_len),
        .wr_burst_addr     (wr_burst_addr),
        .wr_burst_data_req (wr_burst_data_req),
        .wr_burst_data     (wr_burst_data),
        .wr_burst_finish   (wr_burst_finish),
        .m_axi_awid        (awid),
        .m_axi_awaddr      (awaddr),
        .m_axi_awlen       (awlen),
        .m_axi_awsize      (awsize),
        .m_axi_awburst     (awburst),
        .m_axi_awvalid     (awvalid),
        .m_axi_awready     (awready),
        .m_axi_wdata       (wdata),
        .m_axi_wstrb       (wstrb),
        .m_axi_wlast       (wlast),
        .m_axi_wvalid      (wvalid),
        .m_axi_wready      (wready),
        .m_axi_bresp       (bresp),
        .m_axi_bvalid      (bvalid),
        .m_axi_bready      (bready),
        .len_err           (len_err),
        .bresp_err_cnt     (bresp_err_cnt)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Upstream FIFO: each strobe yields the next sequence number one cycle later.
    logic [31:0] fifo_idx;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_idx <= 32'd0;
        end else if (wr_burst_data_req) begin
            wr_burst_data <= {16{fifo_idx}};
            fifo_idx      <= fifo_idx + 32'd1;
        end
    end

    // W ready: always high, or the 1,0,0,1 pattern when bp_mode is set.
    logic        bp_mode = 1'b0;
    logic [3:0]  wr_pat = 4'b1001;
    int unsigned drv_cyc = 0;
    always @(posedge clk) begin
        #1;
        drv_cyc = drv_cyc + 1;
        wready  = bp_mode ? wr_pat[drv_cyc % 4] : 1'b1;
    end

    // Monitor, sampled on the falling edge.
    int unsigned mon_cyc = 0, mon_strobes = 0, mon_beats = 0, mon_fin = 0, mon_aw = 0;
    int unsigned mon_data_err = 0, mon_early = 0, mon_hold_err = 0, mon_max_out = 0;
    int unsigned aw_strobe_mark = 0, b_cyc = 0, fin_cyc = 0, first_cyc = 0, last_cyc = 0;
    int unsigned exp_word = 0, burst_beats = 0, outstanding = 0;
    logic        aw_seen = 1'b0, stalled = 1'b0;
    logic [511:0] stall_data;
    logic [31:0] aw_addr_q[$];
    logic [7:0]  aw_len_q[$];
    int unsigned wlast_len_q[$];

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_word    = 0;
            burst_beats = 0;
            outstanding = 0;
            aw_seen     = 1'b0;
            stalled     = 1'b0;
        end else begin
            mon_cyc++;
            if (wr_burst_data_req) begin
                mon_strobes++;
                outstanding++;
            end
            if (awvalid && awready) begin
                mon_aw++;
                aw_addr_q.push_back(awaddr);
                aw_len_q.push_back(awlen);
                aw_seen        = 1'b1;
                aw_strobe_mark = mon_strobes;
            end
            if (wvalid && !aw_seen) mon_early++;
            if (stalled && (!wvalid || wdata !== stall_data)) mon_hold_err++;
            stalled    = wvalid && !wready;
            stall_data = wdata;
            if (wvalid && wready) begin
                if (wdata[31:0] !== exp_word) mon_data_err++;
                exp_word++;
                mon_beats++;
                outstanding--;
                if (burst_beats == 0) first_cyc = mon_cyc;
                burst_beats++;
                if (wlast) begin
                    wlast_len_q.push_back(burst_beats);
                    last_cyc    = mon_cyc;
                    burst_beats = 0;
                end
            end
            if (outstanding > mon_max_out) mon_max_out = outstanding;
            if (bvalid && bready) b_cyc = mon_cyc;
            if (wr_burst_finish) begin
                mon_fin++;
                fin_cyc = mon_cyc;
                aw_seen = 1'b0;
            end
        end
    end

    task automatic run_burst(input logic [31:0] addr, input logic [9:0] len, input logic [1:0] resp);
        int unsigned f0 = mon_fin;
        int unsigned n = 0;
        wr_burst_addr = addr;
        wr_burst_len  = len;
        bresp         = resp;
        wr_burst_req  = 1'b1;
        @(posedge clk); #1;
        wr_burst_req = 1'b0;
        while (mon_fin == f0 && n < 4000) begin
            @(posedge clk); #1;
            n++;
        end
        if (mon_fin == f0) check_eq("finish_timeout", 64'd0, 64'd1);
        repeat (2) begin @(posedge clk); #1; end
    endtask

    int unsigned s0, b0, f0, a0, d0, e0, h0, q0, n;

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_awvalid", awvalid, 0);
        check_eq("rst_wvalid", wvalid, 0);
        check_eq("rst_data_req", wr_burst_data_req, 0);
        check_eq("rst_finish", wr_burst_finish, 0);
        check_eq("rst_bready", bready, 0);
        check_eq("rst_awaddr", awaddr, 0);
        check_eq("rst_len_err", len_err, 0);
        check_eq("rst_bresp_cnt", bresp_err_cnt, 0);
        rst_n = 1'b1;
        repeat (2) begin @(posedge clk); #1; end

        // Basic burst
        s0 = mon_strobes; b0 = mon_beats; f0 = mon_fin; q0 = wlast_len_q.size();
        run_burst(32'h80, 10'd16, 2'b00);
        check_eq("basic_awaddr", aw_addr_q[$], 32'h400);
        check_eq("basic_awlen", aw_len_q[$], 15);
        check_eq("basic_awsize", awsize, 6);
        check_eq("basic_awburst", awburst, 1);
        check_eq("basic_awid", awid, 0);
        check_eq("basic_wstrb", wstrb, 64'hFFFF_FFFF_FFFF_FFFF);
        check_eq("basic_beats", mon_beats - b0, 16);
        check_eq("basic_strobes", mon_strobes - s0, 16);
        check_eq("basic_wlast_cnt", wlast_len_q.size() - q0, 1);
        check_eq("basic_wlast_pos", wlast_len_q[$], 16);
        check_eq("basic_fin_cnt", mon_fin - f0, 1);
        check_eq("basic_fin_after_b", fin_cyc - b_cyc, 1);
        check_eq("basic_back_to_back_beats", last_cyc - first_cyc, 15);
        check_eq("basic_data_err", mon_data_err, 0);

        // W back-pressure
        bp_mode = 1'b1;
        s0 = mon_strobes; b0 = mon_beats; d0 = mon_data_err; h0 = mon_hold_err;
        run_burst(32'h100, 10'd16, 2'b00);
        bp_mode = 1'b0;
        check_eq("bp_beats", mon_beats - b0, 16);
        check_eq("bp_strobes", mon_strobes - s0, 16);
        check_eq("bp_data_err", mon_data_err - d0, 0);
        check_eq("bp_hold_err", mon_hold_err - h0, 0);
        check_eq("bp_occ_le4", mon_max_out <= 4, 1);
        check_eq("bp_wlast_pos", wlast_len_q[$], 16);

        // AW delay
        awready = 1'b0;
        s0 = mon_strobes; b0 = mon_beats; d0 = mon_data_err; e0 = mon_early;
        fork
            begin
                repeat (20) @(posedge clk);
                #1 awready = 1'b1;
            end
        join_none
        run_burst(32'h200, 10'd16, 2'b00);
        check_eq("awdly_pre_strobes_le3", (aw_strobe_mark - s0) <= 3, 1);
        check_eq("awdly_early_wvalid", mon_early - e0, 0);
        check_eq("awdly_beats", mon_beats - b0, 16);
        check_eq("awdly_data_err", mon_data_err - d0, 0);
        check_eq("awdly_awaddr", aw_addr_q[$], 32'h1000);

        // Back-to-back bursts with req held high
        f0 = mon_fin; a0 = mon_aw; q0 = aw_addr_q.size();
        wr_burst_addr = 32'd0; wr_burst_len = 10'd16; bresp = 2'b00; wr_burst_req = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            n = 0;
            while (mon_fin < f0 + i && n < 2000) begin
                @(posedge clk); #1;
                n++;
            end
            if (mon_fin < f0 + i) check_eq("b2b_timeout", 64'd0, 64'd1);
            wr_burst_addr = 32'(i * 16);
        end
        wr_burst_req = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        check_eq("b2b_fin_cnt", mon_fin - f0, 4);
        check_eq("b2b_aw_cnt", mon_aw - a0, 4);
        check_eq("b2b_addr0", aw_addr_q[q0], 32'h0);
        check_eq("b2b_addr1", aw_addr_q[q0 + 1], 32'h80);
        check_eq("b2b_addr2", aw_addr_q[q0 + 2], 32'h100);
        check_eq("b2b_addr3", aw_addr_q[q0 + 3], 32'h180);

        // Error responses and illegal lengths
        run_burst(32'h10, 10'd16, 2'b00);
        run_burst(32'h20, 10'd16, 2'b10);
        run_burst(32'h30, 10'd16, 2'b10);
        check_eq("err_len_err_before", len_err, 0);
        s0 = mon_strobes; b0 = mon_beats;
        run_burst(32'h40, 10'd0, 2'b00);
        check_eq("err_bresp_cnt", bresp_err_cnt, ExpBrespErr);
        check_eq("err_len_err", len_err, 1);
        check_eq("err_len0_awlen", aw_len_q[$], 0);
        check_eq("err_len0_beats", mon_beats - b0, 1);
        check_eq("err_len0_strobes", mon_strobes - s0, 1);
        check_eq("err_len0_wlast", wlast_len_q[$], 1);
        b0 = mon_beats;
        run_burst(32'h50, 10'd300, 2'b00);
        check_eq("err_len300_awlen", aw_len_q[$], 255);
        check_eq("err_len300_beats", mon_beats - b0, 256);
        check_eq("err_len300_wlast", wlast_len_q[$], 256);
        check_eq("err_data_err", mon_data_err, 0);

        // Reset mid-burst
        b0 = mon_beats; n = 0;
        wr_burst_addr = 32'h60; wr_burst_len = 10'd16; wr_burst_req = 1'b1;
        @(posedge clk); #1;
        wr_burst_req = 1'b0;
        while (mon_beats - b0 < 7 && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("rstmid_reached_beat7", mon_beats - b0 >= 7, 1);
        rst_n = 1'b0;
        #1;
        check_eq("rstmid_awvalid", awvalid, 0);
        check_eq("rstmid_wvalid", wvalid, 0);
        check_eq("rstmid_wlast", wlast, 0);
        check_eq("rstmid_data_req", wr_burst_data_req, 0);
        check_eq("rstmid_bready", bready, 0);
        check_eq("rstmid_awaddr", awaddr, 0);
        check_eq("rstmid_awlen", awlen, 0);
        check_eq("rstmid_wdata", wdata[31:0], 0);
        check_eq("rstmid_len_err", len_err, 0);
        check_eq("rstmid_bresp_cnt", bresp_err_cnt, 0);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        check_eq("rstmid_idle_awvalid", awvalid, 0);
        check_eq("rstmid_idle_data_req", wr_burst_data_req, 0);
        s0 = mon_strobes; b0 = mon_beats; f0 = mon_fin; d0 = mon_data_err;
        run_burst(32'h70, 10'd16, 2'b00);
        check_eq("rstmid_new_beats", mon_beats - b0, 16);
        check_eq("rstmid_new_strobes", mon_strobes - s0, 16);
        check_eq("rstmid_new_fin", mon_fin - f0, 1);
        check_eq("rstmid_new_data_err", mon_data_err - d0, 0);
        check_eq("rstmid_new_awaddr", aw_addr_q[$], 32'h380);
        check_eq("rstmid_new_wlast", wlast_len_q[$], 16);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
